// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - CPU-side load/store request bus of the store buffer
interface store_buffer_if;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_d_in;
  logic        cpu_mrd;
  logic        cpu_mwr;
  logic [31:0] cpu_d_out;
  logic        stall;

  modport master (
    output cpu_adr, cpu_d_in, cpu_mrd, cpu_mwr,
    input  cpu_d_out, stall
  );

  modport slave (
    input  cpu_adr, cpu_d_in, cpu_mrd, cpu_mwr,
    output cpu_d_out, stall
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store FIFO with load overlap check and drain
// Optional exact-hit load forwarding: STORE_BUF_FWD_EN
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  store_buffer_if.slave            cpu,
  output logic [31:0]              mem_adr,
  output logic [31:0]              mem_d_in,
  output logic                     mem_mrd,
  output logic                     mem_mwr,
  input  logic [31:0]              mem_d_out,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   adr_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic          blocked;
  logic          load_go;
  logic          load_stall;
  logic          drain;
  logic          full;
  logic          push;
  logic          store_stall;
`ifdef STORE_BUF_FWD_EN
  logic          hit;
  logic [31:0]   fwd_data;
`endif

  // Scan oldest to newest so the last exact hit found is the newest one.
  always_comb begin
    blocked = 1'b0;
`ifdef STORE_BUF_FWD_EN
    hit      = 1'b0;
    fwd_data = 32'd0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      logic [31:0]   d_ls;
      logic [31:0]   d_sl;
      idx  = head + PW'(k);
      d_ls = cpu.cpu_adr - adr_q[idx];
      d_sl = adr_q[idx] - cpu.cpu_adr;
      if ((CW'(k) < cnt) && ((d_ls <= 32'd3) || (d_sl <= 32'd3))) begin
`ifdef STORE_BUF_FWD_EN
        if (cpu.cpu_adr == adr_q[idx]) begin
          hit      = 1'b1;
          fwd_data = data_q[idx];
        end else begin
          blocked = 1'b1;
        end
`else
        blocked = 1'b1;
`endif
      end
    end
  end

  assign load_go     = cpu.cpu_mrd & ~blocked;
  assign load_stall  = cpu.cpu_mrd & blocked;
  assign drain       = ~load_go & (cnt != '0);
  assign full        = (cnt == CW'(DEPTH));
  assign store_stall = cpu.cpu_mwr & full & ~drain;
  assign cpu.stall   = load_stall | store_stall;
  // A stalled cycle completes neither side, so a blocked load also blocks its paired store.
  assign push        = cpu.cpu_mwr & ~cpu.stall;

`ifdef STORE_BUF_FWD_EN
  assign cpu.cpu_d_out = load_go ? (hit ? fwd_data : mem_d_out) : 32'd0;
`else
  assign cpu.cpu_d_out = load_go ? mem_d_out : 32'd0;
`endif

  assign mem_mrd  = load_go;
  assign mem_mwr  = drain;
  assign mem_adr  = load_go ? cpu.cpu_adr : (drain ? adr_q[head] : 32'd0);
  assign mem_d_in = drain ? data_q[head] : 32'd0;
  assign empty    = (cnt == '0);
  assign count    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (drain) head <= head + PW'(1);
      if (push)  tail <= tail + PW'(1);
      if (push && !drain)      cnt <= cnt + CW'(1);
      else if (!push && drain) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail]  <= cpu.cpu_adr;
      data_q[tail] <= cpu.cpu_d_in;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - vector table, hand sequences and drain scoreboard for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_adr, mem_d_in, mem_d_out;
  logic        mem_mrd, mem_mwr, empty;
  logic [2:0]  count;
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_buffer_if bus();

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .mem_adr   (mem_adr),
    .mem_d_in  (mem_d_in),
    .mem_mrd   (mem_mrd),
    .mem_mwr   (mem_mwr),
    .mem_d_out (mem_d_out),
    .empty     (empty),
    .count     (count)
  );

  // Little-endian byte memory, combinational read, posedge write.
  assign ma        = mem_adr[11:0];
  assign mem_d_out = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_mwr) begin
      mem[ma]         = mem_d_in[7:0];
      mem[ma + 12'd1] = mem_d_in[15:8];
      mem[ma + 12'd2] = mem_d_in[23:16];
      mem[ma + 12'd3] = mem_d_in[31:24];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted stores queued in program order, popped when drained.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } st_t;
  st_t sb[$];
  st_t popped;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_mwr) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_unexpected: got write %h@%h expected none", mem_d_in, mem_adr);
        end else begin
          popped = sb.pop_front();
          chk("drain_adr", mem_adr, popped.adr);
          chk("drain_data", mem_d_in, popped.data);
        end
      end
      if (bus.cpu_mwr && !bus.stall) sb.push_back('{bus.cpu_adr, bus.cpu_d_in});
    end
  end

  typedef struct {
    logic [31:0] adr;
    logic [31:0] din;
    logic        mrd;
    logic        mwr;
    logic        e_stall;
    logic [31:0] e_dout;
    logic        e_mrd;
    logic        e_mwr;
    logic [31:0] e_madr;
    logic [31:0] e_mdin;
    logic [2:0]  e_count;
  } vec_t;
  vec_t vt[8];

  task automatic drive(input logic [31:0] adr, input logic [31:0] din, input logic mrd, input logic mwr);
    bus.cpu_adr  = adr;
    bus.cpu_d_in = din;
    bus.cpu_mrd  = mrd;
    bus.cpu_mwr  = mwr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 20 && !empty; n++) tick();
    chk("wait_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0);

    vt[0] = '{32'h100, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'd0};
    vt[1] = '{32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100, 32'h11223344, 3'd1};
    vt[2] = '{32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'd0};
    vt[3] = '{32'h100, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11223344, 1'b1, 1'b0, 32'h100, 32'h0,        3'd0};
    vt[4] = '{32'h102, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00001122, 1'b1, 1'b0, 32'h102, 32'h0,        3'd0};
    vt[5] = '{32'h300, 32'hAABBCCDD, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h300, 32'h0,        3'd0};
    vt[6] = '{32'h302, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h300, 32'hAABBCCDD, 3'd1};
    vt[7] = '{32'h302, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000AABB, 1'b1, 1'b0, 32'h302, 32'h0,        3'd0};

    tick();
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_mem_mwr", {31'd0, mem_mwr}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic drain, load from memory, partial-overlap stall.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].adr, vt[i].din, vt[i].mrd, vt[i].mwr);
      #3;
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall}, {31'd0, vt[i].e_stall});
      chk($sformatf("v%0d_dout", i), bus.cpu_d_out, vt[i].e_dout);
      chk($sformatf("v%0d_mem_mrd", i), {31'd0, mem_mrd}, {31'd0, vt[i].e_mrd});
      chk($sformatf("v%0d_mem_mwr", i), {31'd0, mem_mwr}, {31'd0, vt[i].e_mwr});
      chk($sformatf("v%0d_mem_adr", i), mem_adr, vt[i].e_madr);
      chk($sformatf("v%0d_mem_d_in", i), mem_d_in, vt[i].e_mdin);
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vt[i].e_count});
      tick();
    end
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    wait_empty();

    // Two stores to 0x200 then a load of the same word.
    drive(32'h200, 32'd5, 1'b0, 1'b1);
    #3 chk("fw_st1_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    drive(32'h200, 32'd9, 1'b1, 1'b1);
    #3;
`ifdef STORE_BUF_FWD_EN
    chk("fw_b_stall", {31'd0, bus.stall}, 32'd0);
    chk("fw_b_dout", bus.cpu_d_out, 32'd5);
    tick();
    chk("fw_b_count", {29'd0, count}, 32'd2);
    drive(32'h200, 32'd0, 1'b1, 1'b0);
    #3;
    chk("fw_c_stall", {31'd0, bus.stall}, 32'd0);
    chk("fw_c_dout", bus.cpu_d_out, 32'd9);
    chk("fw_c_mem_mwr", {31'd0, mem_mwr}, 32'd0);
    tick();
`else
    chk("nf_b_stall", {31'd0, bus.stall}, 32'd1);
    chk("nf_b_dout", bus.cpu_d_out, 32'd0);
    chk("nf_b_mem_mwr", {31'd0, mem_mwr}, 32'd1);
    tick();
    #3;
    chk("nf_c_stall", {31'd0, bus.stall}, 32'd0);
    chk("nf_c_dout", bus.cpu_d_out, 32'd5);
    tick();
    drive(32'h200, 32'd0, 1'b1, 1'b0);
    #3;
    chk("nf_d_stall", {31'd0, bus.stall}, 32'd1);
    chk("nf_d_mem_mrd", {31'd0, mem_mrd}, 32'd0);
    tick();
    #3;
    chk("nf_e_stall", {31'd0, bus.stall}, 32'd0);
    chk("nf_e_dout", bus.cpu_d_out, 32'd9);
    tick();
`endif
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    wait_empty();
    drive(32'h200, 32'd0, 1'b1, 1'b0);
    #3 chk("fw_final_mem", bus.cpu_d_out, 32'd9);
    tick();

    // Simultaneous load and store to 0x400 while 0x400<-7 is buffered.
    drive(32'h400, 32'd7, 1'b0, 1'b1);
    tick();
    drive(32'h400, 32'd8, 1'b1, 1'b1);
    #3;
`ifdef STORE_BUF_FWD_EN
    chk("ls_stall", {31'd0, bus.stall}, 32'd0);
    chk("ls_dout", bus.cpu_d_out, 32'd7);
    tick();
    chk("ls_count", {29'd0, count}, 32'd2);
`else
    chk("ls_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    #3;
    chk("ls_stall_held", {31'd0, bus.stall}, 32'd0);
    chk("ls_dout", bus.cpu_d_out, 32'd7);
    tick();
    chk("ls_count", {29'd0, count}, 32'd1);
`endif
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    wait_empty();
    drive(32'h400, 32'd0, 1'b1, 1'b0);
    #3 chk("ls_final_mem", bus.cpu_d_out, 32'd8);
    tick();

    // Fill with loads starving the drain, then full store stalls until the load drops.
    for (int k = 0; k < 4; k++) begin
      drive(32'h500 + 32'(k * 16), 32'hA0 + 32'(k), 1'b1, 1'b1);
      #3 chk($sformatf("full_st%0d_stall", k), {31'd0, bus.stall}, 32'd0);
      tick();
    end
    chk("full_count", {29'd0, count}, 32'd4);
    drive(32'h540, 32'hA4, 1'b1, 1'b1);
    #3 chk("full_5th_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    chk("full_count_held", {29'd0, count}, 32'd4);
    drive(32'h540, 32'hA4, 1'b0, 1'b1);
    #3;
    chk("full_nold_stall", {31'd0, bus.stall}, 32'd0);
    chk("full_nold_mem_mwr", {31'd0, mem_mwr}, 32'd1);
    chk("full_nold_mem_adr", mem_adr, 32'h500);
    tick();
    chk("full_pushpop_count", {29'd0, count}, 32'd4);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    wait_empty();

    // Reset with three stores queued: they must never reach memory.
    for (int k = 0; k < 3; k++) begin
      drive(32'h600 + 32'(k * 16), 32'hC0 + 32'(k), 1'b1, 1'b1);
      tick();
    end
    chk("mid_count", {29'd0, count}, 32'd3);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_mem_mwr", {31'd0, mem_mwr}, 32'd0);
    chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst_mwr%0d", k), {31'd0, mem_mwr}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(32'h600 + 32'(k * 16), 32'd0, 1'b1, 1'b0);
      #3 chk($sformatf("post_rst_mem%0d", k), bus.cpu_d_out, 32'd0);
      tick();
    end

    drive(32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
